// File: rtl/writeback_stage_if.sv
// MEM->WB handshake, data-memory response and register-file write port for writeback_stage.
// Handshake: memValid is the valid and ~wbStall is the ready; a transfer happens on a posedge when both are high and flush is low.
interface writeback_stage_if #(
    parameter int RETIRE_W = 32
);
    logic                flush;
    logic                memValid;
    logic                memRegWrite;
    logic                memToReg;
    logic                memLink;
    logic [2:0]          memLoadType;
    logic [4:0]          memWriteReg;
    logic [31:0]         memAluResult;
    logic [31:0]         memPcPlus8;
    logic [1:0]          memAddrLow;
    logic                dmemRvalid;
    logic [31:0]         dmemRdata;
    logic                RegWrite;
    logic [4:0]          writeReg;
    logic [31:0]         writeData;
    logic                wbStall;
    logic [RETIRE_W-1:0] retiredCount;
    logic                dbgState;

    modport master (
        output flush, memValid, memRegWrite, memToReg, memLink, memLoadType,
               memWriteReg, memAluResult, memPcPlus8, memAddrLow, dmemRvalid, dmemRdata,
        input  RegWrite, writeReg, writeData, wbStall, retiredCount, dbgState
    );

    modport slave (
        input  flush, memValid, memRegWrite, memToReg, memLink, memLoadType,
               memWriteReg, memAluResult, memPcPlus8, memAddrLow, dmemRvalid, dmemRdata,
        output RegWrite, writeReg, writeData, wbStall, retiredCount, dbgState
    );
endinterface

// File: rtl/writeback_stage.sv
// MIPS WB stage: selects ALU/link/extended-load result, waits on late loads, drives the RF write port.
module writeback_stage #(
    parameter int RETIRE_W   = 32,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic            CLK,
    input  logic            RSTn,
    writeback_stage_if.slave wb
);
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wbState_t;

    wbState_t              state, stateNext;
    logic [2:0]            pendType;
    logic [4:0]            pendReg;
    logic [1:0]            pendAddr;
    logic                  pendWrite;
    logic                  regWriteQ;
    logic [4:0]            writeRegQ;
    logic [31:0]           writeDataQ;
    logic [RETIRE_W-1:0]   retiredCount;

    logic                  accept;
    logic                  commit;
    logic                  commitWrite;
    logic [4:0]            commitReg;
    logic [31:0]           commitData;
    logic                  captureLoad;

    function automatic logic [31:0] extendLoad(input logic [2:0] loadType,
                                               input logic [1:0] addrLow,
                                               input logic [31:0] rdata);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        byteVal = rdata[{addrLow, 3'b000} +: 8];
        // Halves ignore addrLow[0]; misaligned halves silently use the aligned lane.
        halfVal = rdata[{addrLow[1], 4'b0000} +: 16];
        case (loadType)
            3'd1:    extendLoad = {{24{byteVal[7]}}, byteVal};
            3'd2:    extendLoad = {24'd0, byteVal};
            3'd3:    extendLoad = {{16{halfVal[15]}}, halfVal};
            3'd4:    extendLoad = {16'd0, halfVal};
            default: extendLoad = rdata;
        endcase
    endfunction

    assign accept = (state == IDLE) && wb.memValid && !wb.flush;

    always_comb begin
        stateNext   = state;
        commit      = 1'b0;
        commitWrite = 1'b0;
        commitReg   = writeRegQ;
        commitData  = writeDataQ;
        captureLoad = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!wb.memToReg) begin
                        commit      = 1'b1;
                        commitWrite = wb.memRegWrite;
                        commitReg   = wb.memWriteReg;
                        commitData  = wb.memLink ? wb.memPcPlus8 : wb.memAluResult;
                    end else if (wb.dmemRvalid) begin
                        commit      = 1'b1;
                        commitWrite = wb.memRegWrite;
                        commitReg   = wb.memWriteReg;
                        commitData  = extendLoad(wb.memLoadType, wb.memAddrLow, wb.dmemRdata);
                    end else begin
                        captureLoad = 1'b1;
                        stateNext   = WAIT;
                    end
                end
            end
            WAIT: begin
                // MEM inputs are frozen upstream while stalled, so only the latched load matters.
                if (wb.dmemRvalid) begin
                    commit      = 1'b1;
                    commitWrite = pendWrite;
                    commitReg   = pendReg;
                    commitData  = extendLoad(pendType, pendAddr, wb.dmemRdata);
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= IDLE;
            pendType     <= 3'd0;
            pendReg      <= 5'd0;
            pendAddr     <= 2'd0;
            pendWrite    <= 1'b0;
            regWriteQ    <= 1'b0;
            writeRegQ    <= 5'd0;
            writeDataQ   <= 32'd0;
            retiredCount <= '0;
        end else begin
            state     <= stateNext;
            regWriteQ <= commit && commitWrite && !(ZERO_GUARD && (commitReg == 5'd0));
            if (captureLoad) begin
                pendType  <= wb.memLoadType;
                pendReg   <= wb.memWriteReg;
                pendAddr  <= wb.memAddrLow;
                pendWrite <= wb.memRegWrite;
            end
            if (commit) begin
                writeRegQ    <= commitReg;
                writeDataQ   <= commitData;
                retiredCount <= retiredCount + RETIRE_W'(1);
            end
        end
    end

    assign wb.RegWrite     = regWriteQ;
    assign wb.writeReg     = writeRegQ;
    assign wb.writeData    = writeDataQ;
    assign wb.wbStall      = (state == WAIT);
    assign wb.retiredCount = retiredCount;
    assign wb.dbgState     = state;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and random checks of writeback_stage against a queue-based reference model.
module tb_writeback_stage;
    localparam int RW = 8;

    logic CLK;
    logic RSTn;
    int   nChecks = 0;
    int   nFails  = 0;

    writeback_stage_if #(.RETIRE_W(RW)) wbIf ();

    writeback_stage #(.RETIRE_W(RW), .ZERO_GUARD(1'b1)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .wb   (wbIf)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: outstanding loads as a queue, results by plain arithmetic
    typedef struct {
        logic [2:0] loadType;
        logic [4:0] rd;
        logic [1:0] addrLow;
        logic       we;
    } pend_t;

    pend_t        pendQ[$];
    logic [36:0]  exp_q[$];
    int           mdlCount;
    logic [4:0]   mdlReg;
    logic [31:0]  mdlData;

    function automatic logic [31:0] refLoad(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
        longint b, h;
        b = longint'(w >> (8 * int'(a))) % 256;
        h = longint'(w >> (16 * (int'(a) / 2))) % 65536;
        case (t)
            3'd1:    return 32'(b >= 128 ? b - 256 : b);
            3'd2:    return 32'(b);
            3'd3:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idleInputs();
        wbIf.flush        = 1'b0;
        wbIf.memValid     = 1'b0;
        wbIf.memRegWrite  = 1'b0;
        wbIf.memToReg     = 1'b0;
        wbIf.memLink      = 1'b0;
        wbIf.memLoadType  = 3'd0;
        wbIf.memWriteReg  = 5'd0;
        wbIf.memAluResult = 32'd0;
        wbIf.memPcPlus8   = 32'd0;
        wbIf.memAddrLow   = 2'd0;
        wbIf.dmemRvalid   = 1'b0;
        wbIf.dmemRdata    = 32'd0;
    endtask

    task automatic modelReset();
        pendQ.delete();
        exp_q.delete();
        mdlCount = 0;
        mdlReg   = 5'd0;
        mdlData  = 32'd0;
    endtask

    // One clock: predict from the current inputs, step the edge, compare #1 later.
    task automatic cycle();
        bit          cm;
        bit          we;
        bit          expWe;
        logic [4:0]  rd;
        logic [31:0] d;
        pend_t       p;
        cm = 0; we = 0; rd = 5'd0; d = 32'd0;
        if (pendQ.size() != 0) begin
            if (wbIf.dmemRvalid) begin
                p  = pendQ.pop_front();
                cm = 1; we = p.we; rd = p.rd;
                d  = refLoad(p.loadType, p.addrLow, wbIf.dmemRdata);
            end
        end else if (wbIf.memValid && !wbIf.flush) begin
            if (!wbIf.memToReg) begin
                cm = 1; we = wbIf.memRegWrite; rd = wbIf.memWriteReg;
                d  = wbIf.memLink ? wbIf.memPcPlus8 : wbIf.memAluResult;
            end else if (wbIf.dmemRvalid) begin
                cm = 1; we = wbIf.memRegWrite; rd = wbIf.memWriteReg;
                d  = refLoad(wbIf.memLoadType, wbIf.memAddrLow, wbIf.dmemRdata);
            end else begin
                p.loadType = wbIf.memLoadType;
                p.rd       = wbIf.memWriteReg;
                p.addrLow  = wbIf.memAddrLow;
                p.we       = wbIf.memRegWrite;
                pendQ.push_back(p);
            end
        end
        expWe = cm && we && (rd != 5'd0);
        if (cm) begin
            mdlReg   = rd;
            mdlData  = d;
            mdlCount = (mdlCount + 1) % (1 << RW);
            if (expWe) exp_q.push_back({rd, d});
        end
        @(posedge CLK);
        #1;
        check("RegWrite", 64'(wbIf.RegWrite), 64'(expWe));
        check("wbStall", 64'(wbIf.wbStall), 64'(pendQ.size() != 0));
        check("retiredCount", 64'(wbIf.retiredCount), 64'(mdlCount));
        check("writeRegHold", 64'(wbIf.writeReg), 64'(mdlReg));
        check("writeDataHold", 64'(wbIf.writeData), 64'(mdlData));
        if (expWe && exp_q.size() != 0) check("rfWrite", 64'({wbIf.writeReg, wbIf.writeData}), 64'(exp_q.pop_front()));
    endtask

    task automatic aluOp(input logic [4:0] rd, input logic [31:0] alu, input bit link, input logic [31:0] pc8);
        idleInputs();
        wbIf.memValid     = 1'b1;
        wbIf.memRegWrite  = 1'b1;
        wbIf.memWriteReg  = rd;
        wbIf.memAluResult = alu;
        wbIf.memLink      = link;
        wbIf.memPcPlus8   = pc8;
        cycle();
        idleInputs();
    endtask

    task automatic readyLoad(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w, input logic [4:0] rd);
        idleInputs();
        wbIf.memValid    = 1'b1;
        wbIf.memRegWrite = 1'b1;
        wbIf.memToReg    = 1'b1;
        wbIf.memLoadType = t;
        wbIf.memAddrLow  = a;
        wbIf.memWriteReg = rd;
        wbIf.dmemRvalid  = 1'b1;
        wbIf.dmemRdata   = w;
        cycle();
        idleInputs();
    endtask

    initial begin
        idleInputs();
        modelReset();
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rstRegWrite", 64'(wbIf.RegWrite), 64'd0);
        check("rstWriteReg", 64'(wbIf.writeReg), 64'd0);
        check("rstWriteData", 64'(wbIf.writeData), 64'd0);
        check("rstCount", 64'(wbIf.retiredCount), 64'd0);
        check("rstStall", 64'(wbIf.wbStall), 64'd0);
        RSTn = 1'b1;
        cycle();

        // ALU commit, then a bubble
        aluOp(5'd8, 32'h1234_5678, 1'b0, 32'd0);
        check("aluData", 64'(wbIf.writeData), 64'h1234_5678);
        check("aluCount", 64'(wbIf.retiredCount), 64'd1);
        cycle();
        check("aluPulse", 64'(wbIf.RegWrite), 64'd0);

        // Ready-load extension cases
        readyLoad(3'd1, 2'd3, 32'h80FF_00AA, 5'd9);
        check("LB", 64'(wbIf.writeData), 64'hFFFF_FF80);
        readyLoad(3'd2, 2'd3, 32'h80FF_00AA, 5'd10);
        check("LBU", 64'(wbIf.writeData), 64'h0000_0080);
        readyLoad(3'd3, 2'd2, 32'h80FF_00AA, 5'd11);
        check("LH", 64'(wbIf.writeData), 64'hFFFF_80FF);
        readyLoad(3'd4, 2'd2, 32'h80FF_00AA, 5'd12);
        check("LHU", 64'(wbIf.writeData), 64'h0000_80FF);
        readyLoad(3'd0, 2'd0, 32'h80FF_00AA, 5'd13);
        check("LW", 64'(wbIf.writeData), 64'h80FF_00AA);
        readyLoad(3'd3, 2'd1, 32'h80FF_00AA, 5'd14);
        check("LHodd", 64'(wbIf.writeData), 64'h0000_00AA);

        // Late load: data arrives after the MEM contents were held for a while
        idleInputs();
        wbIf.memValid    = 1'b1;
        wbIf.memRegWrite = 1'b1;
        wbIf.memToReg    = 1'b1;
        wbIf.memWriteReg = 5'd4;
        cycle();
        check("lateStall1", 64'(wbIf.wbStall), 64'd1);
        cycle();
        cycle();
        check("lateStall3", 64'(wbIf.wbStall), 64'd1);
        wbIf.dmemRvalid = 1'b1;
        wbIf.dmemRdata  = 32'hCAFE_F00D;
        cycle();
        check("lateData", 64'(wbIf.writeData), 64'hCAFE_F00D);
        check("lateReg", 64'(wbIf.writeReg), 64'd4);
        idleInputs();
        cycle();

        // Link and $0 destination
        aluOp(5'd31, 32'hDEAD_BEEF, 1'b1, 32'h0040_0010);
        check("jalData", 64'(wbIf.writeData), 64'h0040_0010);
        aluOp(5'd0, 32'h1111_1111, 1'b0, 32'd0);
        check("zeroGuard", 64'(wbIf.RegWrite), 64'd0);

        // Flushed instruction and stray dmemRvalid in IDLE
        idleInputs();
        wbIf.memValid    = 1'b1;
        wbIf.memRegWrite = 1'b1;
        wbIf.memWriteReg = 5'd5;
        wbIf.flush       = 1'b1;
        cycle();
        idleInputs();
        wbIf.dmemRvalid = 1'b1;
        wbIf.dmemRdata  = 32'h5555_AAAA;
        cycle();
        idleInputs();

        // Reset while a load is outstanding
        wbIf.memValid    = 1'b1;
        wbIf.memRegWrite = 1'b1;
        wbIf.memToReg    = 1'b1;
        wbIf.memWriteReg = 5'd7;
        cycle();
        #2;
        RSTn = 1'b0;
        #1;
        check("midRstRegWrite", 64'(wbIf.RegWrite), 64'd0);
        check("midRstStall", 64'(wbIf.wbStall), 64'd0);
        check("midRstCount", 64'(wbIf.retiredCount), 64'd0);
        modelReset();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        idleInputs();
        wbIf.dmemRvalid = 1'b1;
        wbIf.dmemRdata  = 32'h7777_7777;
        cycle();
        idleInputs();
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            wbIf.flush        = ($urandom_range(0, 7) == 0);
            wbIf.memValid     = ($urandom_range(0, 3) != 0);
            wbIf.memRegWrite  = ($urandom_range(0, 5) != 0);
            wbIf.memToReg     = $urandom_range(0, 1);
            wbIf.memLink      = $urandom_range(0, 1);
            wbIf.memLoadType  = 3'($urandom_range(0, 7));
            wbIf.memWriteReg  = 5'($urandom_range(0, 31));
            wbIf.memAluResult = $urandom;
            wbIf.memPcPlus8   = $urandom;
            wbIf.memAddrLow   = 2'($urandom_range(0, 3));
            wbIf.dmemRvalid   = ($urandom_range(0, 2) == 0);
            wbIf.dmemRdata    = $urandom;
            cycle();
        end
        idleInputs();
        wbIf.dmemRvalid = 1'b1;
        cycle();
        idleInputs();

        // Drive the counter to its top value, then one more commit must wrap to 0
        for (int i = 0; i < (1 << RW) && mdlCount != (1 << RW) - 1; i++) aluOp(5'd3, 32'(i), 1'b0, 32'd0);
        check("preWrap", 64'(wbIf.retiredCount), 64'((1 << RW) - 1));
        aluOp(5'd3, 32'hABCD_0123, 1'b0, 32'd0);
        check("wrap", 64'(wbIf.retiredCount), 64'd0);
        cycle();

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
